nco_mix_framer: RTL and testbench

Quadrature down-conversion stage directly downstream of the NCO. It multiplies each real ADC sample by the NCO cosine and negated sine, then rounds and saturates the products. The resulting I/Q stream is packed into fixed-length frames with start-of-packet (sop) and end-of-packet (eop) markers for the streaming FFT sink. FFT back-pressure never breaks frame alignment: an interrupted frame is completed with zero padding.

---
 rtl/nco_mix_framer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_nco_mix_framer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_mix_framer.sv
// nco_mix_framer: quadrature down-conversion of a real ADC stream against the
// NCO sin/cos outputs, followed by round/saturate and fixed-length framing for
// a streaming FFT sink. A frame that loses a sample to back-pressure is closed
// out with zero samples so that frame alignment is never lost.
//
// Pipeline: S1 input register, S2 products, S3 round/saturate + framing FSM
// (registered outputs). Accepted input to output is exactly 3 clocks.

module nco_mix_framer #(
    parameter int DW       = 12,
    parameter int MPR      = 16,
    parameter int OW       = 16,
    parameter int FFT_LEN  = 1024,
    parameter int LOG2_LEN = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DW-1:0]     adc_i,
    input  logic              adc_valid,
    input  logic [MPR-1:0]    nco_sin,
    input  logic [MPR-1:0]    nco_cos,
    input  logic              nco_valid,
    input  logic              sink_ready,
    output logic [OW-1:0]     i_o,
    output logic [OW-1:0]     q_o,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic [15:0]       frames_done
);

    // Full product width and the position of the retained output field.
    localparam int PW = DW + MPR;
    localparam int SH = PW - 1 - OW;

    // Half an output LSB, added before truncation (round half up).
    localparam logic [PW:0] RND_HALF = {{PW{1'b0}}, 1'b1} << (SH - 1);

    localparam logic [LOG2_LEN-1:0] CNT_LAST = LOG2_LEN'(FFT_LEN - 1);
    localparam logic [LOG2_LEN-1:0] CNT_ONE  = {{(LOG2_LEN-1){1'b0}}, 1'b1};
    localparam logic [LOG2_LEN-1:0] CNT_ZERO = {LOG2_LEN{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Saturate a rounded sum. top holds the guard bits plus the output sign;
    // they must all agree for the retained field to be representable.
    function automatic logic [OW-1:0] sat_round(input logic [2:0] top,
                                                input logic [OW-1:0] mid);
        logic [OW-1:0] res;
        if (top == 3'b000 || top == 3'b111) begin
            res = mid;
        end else if (top[2] == 1'b0) begin
            res = {1'b0, {(OW-1){1'b1}}};
        end else begin
            res = {1'b1, {(OW-1){1'b0}}};
        end
        return res;
    endfunction

    // ---------------- S1: input capture ----------------
    logic                  v1_r;
    logic signed [DW-1:0]  adc_r;
    logic signed [MPR-1:0] sin_r;
    logic signed [MPR-1:0] cos_r;
    logic                  accept_s;

    assign accept_s = adc_valid & nco_valid;

    // Register an accepted sample together with its NCO phase values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_r  <= 1'b0;
            adc_r <= {DW{1'b0}};
            sin_r <= {MPR{1'b0}};
            cos_r <= {MPR{1'b0}};
        end else begin
            v1_r <= accept_s;
            if (accept_s) begin
                adc_r <= adc_i;
                sin_r <= nco_sin;
                cos_r <= nco_cos;
            end
        end
    end

    // ---------------- S2: products ----------------
    logic signed [PW-1:0] adc_x_s;
    logic signed [PW-1:0] sin_x_s;
    logic signed [PW-1:0] cos_x_s;
    logic signed [PW-1:0] prod_i_s;
    logic signed [PW-1:0] prod_q_s;
    logic                 v2_r;
    logic signed [PW-1:0] pi_r;
    logic signed [PW-1:0] pq_r;

    // Sign-extend first so multiply and negate happen at full product width;
    // the largest magnitude product (2^(PW-2)) negates without wrapping.
    assign adc_x_s  = PW'(adc_r);
    assign sin_x_s  = PW'(sin_r);
    assign cos_x_s  = PW'(cos_r);
    assign prod_i_s = adc_x_s * cos_x_s;
    assign prod_q_s = -(adc_x_s * sin_x_s);

    // Register the I product and the negated Q product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_r <= 1'b0;
            pi_r <= {PW{1'b0}};
            pq_r <= {PW{1'b0}};
        end else begin
            v2_r <= v1_r;
            pi_r <= prod_i_s;
            pq_r <= prod_q_s;
        end
    end

    // ---------------- S3: round / saturate ----------------
    logic [PW:0]   rsum_i_s;
    logic [PW:0]   rsum_q_s;
    logic [OW-1:0] rnd_i_s;
    logic [OW-1:0] rnd_q_s;
    logic          unused_rnd_s;

    // One extra guard bit keeps the rounding add itself from overflowing.
    assign rsum_i_s = {pi_r[PW-1], pi_r} + RND_HALF;
    assign rsum_q_s = {pq_r[PW-1], pq_r} + RND_HALF;
    assign rnd_i_s  = sat_round(rsum_i_s[PW:PW-2], rsum_i_s[PW-2:SH]);
    assign rnd_q_s  = sat_round(rsum_q_s[PW:PW-2], rsum_q_s[PW-2:SH]);

    // Fraction bits below the output LSB are discarded after rounding.
    assign unused_rnd_s = ^{rsum_i_s[SH-1:0], rsum_q_s[SH-1:0]};

    // ---------------- S3: framing FSM ----------------
    state_t              state_r;
    state_t              nxt_state_s;
    logic [LOG2_LEN-1:0] cnt_r;
    logic [LOG2_LEN-1:0] nxt_cnt_s;
    logic                emit_s;
    logic                emit_zero_s;
    logic                sop_s;
    logic                eop_s;
    logic                set_ovr_s;

    // Frame state and slot counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= nxt_state_s;
            cnt_r   <= nxt_cnt_s;
        end
    end

    // Next-state and emit decisions, driven by the S3 sample valid (v2_r).
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        emit_s      = 1'b0;
        emit_zero_s = 1'b0;
        sop_s       = 1'b0;
        eop_s       = 1'b0;
        set_ovr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Samples arriving while disabled or not ready are dropped
                // silently; they do not belong to any frame yet.
                if (v2_r && enable && sink_ready) begin
                    emit_s      = 1'b1;
                    sop_s       = 1'b1;
                    nxt_cnt_s   = CNT_ONE;
                    nxt_state_s = ST_RUN;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (v2_r) begin
                    if (sink_ready) begin
                        emit_s = 1'b1;
                        if (cnt_r == CNT_LAST) begin
                            eop_s       = 1'b1;
                            nxt_cnt_s   = CNT_ZERO;
                            nxt_state_s = ST_IDLE;
                        end else begin
                            nxt_cnt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        // Lost sample: its slot is refilled with zeros later.
                        set_ovr_s   = 1'b1;
                        nxt_state_s = ST_FLUSH;
                    end
                end else begin
                    nxt_state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (sink_ready) begin
                    emit_s      = 1'b1;
                    emit_zero_s = 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        eop_s       = 1'b1;
                        nxt_cnt_s   = CNT_ZERO;
                        nxt_state_s = ST_IDLE;
                    end else begin
                        nxt_cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    nxt_state_s = ST_FLUSH;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // ---------------- Output registers ----------------
    logic [OW-1:0] i_r;
    logic [OW-1:0] q_r;
    logic          out_valid_r;
    logic          out_sop_r;
    logic          out_eop_r;
    logic          overrun_r;
    logic [15:0]   frames_done_r;

    // Output strobes and data; data holds its last value between samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_r         <= {OW{1'b0}};
            q_r         <= {OW{1'b0}};
            out_valid_r <= 1'b0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
        end else begin
            out_valid_r <= emit_s;
            out_sop_r   <= sop_s;
            out_eop_r   <= eop_s;
            if (emit_s) begin
                i_r <= emit_zero_s ? {OW{1'b0}} : rnd_i_s;
                q_r <= emit_zero_s ? {OW{1'b0}} : rnd_q_s;
            end
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
        end else if (set_ovr_s) begin
            overrun_r <= 1'b1;
        end else if (ovr_clr) begin
            overrun_r <= 1'b0;
        end
    end

    // Completed-frame counter, including frames closed by zero padding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frames_done_r <= 16'd0;
        end else if (eop_s) begin
            frames_done_r <= frames_done_r + 16'd1;
        end
    end

    assign i_o         = i_r;
    assign q_o         = q_r;
    assign out_valid   = out_valid_r;
    assign out_sop     = out_sop_r;
    assign out_eop     = out_eop_r;
    assign overrun     = overrun_r;
    assign frames_done = frames_done_r;

endmodule

// File: tb/tb_nco_mix_framer.sv
// Self-checking bench for nco_mix_framer (FFT_LEN=8). A behavioural model
// computes products with integer arithmetic and tracks frame slots; directed
// phases cover the listed scenarios, then a randomized phase runs.

module tb_nco_mix_framer;

    localparam int DW       = 12;
    localparam int MPR      = 16;
    localparam int OW       = 16;
    localparam int FFT_LEN  = 8;
    localparam int LOG2_LEN = 3;

    localparam longint MAXV = (longint'(1) <<< (OW-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (OW-1));

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           enable = 1'b0;
    logic [DW-1:0]  adc_i = '0;
    logic           adc_valid = 1'b0;
    logic [MPR-1:0] nco_sin = '0;
    logic [MPR-1:0] nco_cos = '0;
    logic           nco_valid = 1'b0;
    logic           sink_ready = 1'b0;
    logic           ovr_clr = 1'b0;
    logic [OW-1:0]  i_o;
    logic [OW-1:0]  q_o;
    logic           out_valid;
    logic           out_sop;
    logic           out_eop;
    logic           overrun;
    logic [15:0]    frames_done;

    nco_mix_framer #(
        .DW(DW), .MPR(MPR), .OW(OW), .FFT_LEN(FFT_LEN), .LOG2_LEN(LOG2_LEN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .adc_i(adc_i), .adc_valid(adc_valid),
        .nco_sin(nco_sin), .nco_cos(nco_cos), .nco_valid(nco_valid),
        .sink_ready(sink_ready),
        .i_o(i_o), .q_o(q_o), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop),
        .overrun(overrun), .ovr_clr(ovr_clr), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Two-deep delay line of accepted samples (already mixed and rounded),
    // then frame-slot bookkeeping.
    bit            m_v [2];
    logic [OW-1:0] m_i [2];
    logic [OW-1:0] m_q [2];
    bit            mdl_in_frame;
    bit            mdl_flush;
    int            mdl_pos;
    logic          e_valid, e_sop, e_eop, e_ovr;
    logic [OW-1:0] e_i, e_q;
    logic [15:0]   e_frames;

    function automatic logic [OW-1:0] mix_round(input longint p);
        longint r;
        r = (p + (longint'(1) <<< (DW+MPR-2-OW))) >>> (DW+MPR-1-OW);
        if (r > MAXV) r = MAXV;
        else if (r < MINV) r = MINV;
        return r[OW-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 1'b0; m_i[k] = '0; m_q[k] = '0;
        end
        mdl_in_frame = 1'b0; mdl_flush = 1'b0; mdl_pos = 0;
        e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_ovr = 1'b0;
        e_i = '0; e_q = '0; e_frames = '0;
    endtask

    task automatic end_slot();
        if (mdl_pos == FFT_LEN-1) begin
            e_eop = 1'b1;
            e_frames = e_frames + 16'd1;
            mdl_in_frame = 1'b0;
            mdl_flush = 1'b0;
            mdl_pos = 0;
        end else begin
            mdl_pos++;
        end
    endtask

    task automatic model_edge();
        bit     ovr_set;
        longint a, s, c;
        if (!reset_n) begin
            model_reset();
            return;
        end
        ovr_set = 1'b0;
        e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0;
        if (mdl_flush) begin
            if (sink_ready) begin
                e_valid = 1'b1; e_i = '0; e_q = '0;
                end_slot();
            end
        end else if (mdl_in_frame) begin
            if (m_v[1]) begin
                if (sink_ready) begin
                    e_valid = 1'b1; e_i = m_i[1]; e_q = m_q[1];
                    end_slot();
                end else begin
                    ovr_set = 1'b1;
                    mdl_flush = 1'b1;
                end
            end
        end else if (m_v[1] && enable && sink_ready) begin
            e_valid = 1'b1; e_sop = 1'b1; e_i = m_i[1]; e_q = m_q[1];
            mdl_in_frame = 1'b1;
            mdl_pos = 1;
        end
        if (ovr_set) e_ovr = 1'b1;
        else if (ovr_clr) e_ovr = 1'b0;
        a = longint'($signed(adc_i));
        s = longint'($signed(nco_sin));
        c = longint'($signed(nco_cos));
        m_v[1] = m_v[0]; m_i[1] = m_i[0]; m_q[1] = m_q[0];
        m_v[0] = adc_valid && nco_valid;
        m_i[0] = mix_round(a * c);
        m_q[0] = mix_round(-(a * s));
    endtask

    // One clock: update model at the edge, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("ctl{valid,sop,eop,ovr}", {28'd0, out_valid, out_sop, out_eop, overrun},
              {28'd0, e_valid, e_sop, e_eop, e_ovr});
        check("i_o", {16'd0, i_o}, {16'd0, e_i});
        check("q_o", {16'd0, q_o}, {16'd0, e_q});
        check("frames_done", {16'd0, frames_done}, {16'd0, e_frames});
    endtask

    task automatic drive(input bit en, input logic [DW-1:0] a, input logic [MPR-1:0] s,
                         input logic [MPR-1:0] c, input bit av, input bit nv, input bit rdy);
        enable = en; adc_i = a; nco_sin = s; nco_cos = c;
        adc_valid = av; nco_valid = nv; sink_ready = rdy;
    endtask

    task automatic wait_pos(input int target, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            step();
            hit = mdl_in_frame && !mdl_flush && (mdl_pos == target);
        end
        check(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit done = !mdl_in_frame;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            done = !mdl_in_frame;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    int pulses;
    int eop_at;

    initial begin
        model_reset();
        // ---- reset state ----
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_frames", {16'd0, frames_done}, 32'd0);

        // ---- 1: basic mix, latency, framing ----
        reset_n = 1'b1;
        drive(1'b1, 12'd1024, 16'd0, 16'd16384, 1'b1, 1'b1, 1'b1);
        step(); step();
        check("lat_no_early_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_first_valid", {30'd0, out_valid, out_sop}, 32'd3);
        check("basic_i", {16'd0, i_o}, 32'h2000);
        check("basic_q", {16'd0, q_o}, 32'h0000);
        repeat (7) step();
        check("first_eop", {31'd0, out_eop}, 32'd1);
        check("frames_after_one", {16'd0, frames_done}, 32'd1);
        step();
        check("b2b_sop", {31'd0, out_sop}, 32'd1);
        repeat (7) step();

        // ---- 2: saturation and rounding ----
        drive(1'b1, 12'h800, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1);
        repeat (4) step();
        check("sat_i", {16'd0, i_o}, 32'h7FFF);
        check("sat_q", {16'd0, q_o}, 32'h8000);
        drive(1'b1, 12'd3, 16'd0, 16'd1024, 1'b1, 1'b1, 1'b1);
        repeat (4) step();
        check("round_half_up_i", {16'd0, i_o}, 32'd2);

        // ---- 3: back-pressure mid-frame, flush, overrun clear priority ----
        drive(1'b1, 12'd700, 16'd5000, 16'd9000, 1'b1, 1'b1, 1'b1);
        wait_pos(5, "wait_slot5_a");
        sink_ready = 1'b0;
        step(); step();
        check("ovr_set", {31'd0, overrun}, 32'd1);
        sink_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("flush_zero", {i_o, q_o}, 32'd0);
        end
        check("flush_eop", {31'd0, out_eop}, 32'd1);
        wait_pos(5, "wait_slot5_b");
        sink_ready = 1'b0; ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("ovr_set_beats_clr", {31'd0, overrun}, 32'd1);
        sink_ready = 1'b1;
        wait_idle("flush_done_b");
        enable = 1'b0; ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // ---- 4: enable gating ----
        for (int k = 0; k < 12; k++) begin
            step();
            check("disabled_no_valid", {31'd0, out_valid}, 32'd0);
        end
        enable = 1'b1;
        pulses = 0; eop_at = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (out_valid) begin
                pulses++;
                if (pulses == 1) check("en_first_sop", {31'd0, out_sop}, 32'd1);
                if (out_eop) eop_at = pulses;
            end
            if (mdl_in_frame && mdl_pos == 3) enable = 1'b0;
        end
        check("en_drop_frame_len", pulses, 32'd8);
        check("en_drop_eop_slot", eop_at, 32'd8);

        // ---- 5: nco_valid low, then gapped input ----
        nco_valid = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("nco_invalid_no_valid", {31'd0, out_valid}, 32'd0);
        end
        nco_valid = 1'b1;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            adc_valid = (k % 3 == 0);
            adc_i = DW'($urandom);
            step();
            if (out_valid) begin
                pulses++;
                check("gap_sop", {31'd0, out_sop}, {31'd0, (pulses % 8) == 1});
                check("gap_eop", {31'd0, out_eop}, {31'd0, (pulses % 8) == 0});
            end
        end
        check("gap_pulse_count", pulses, 32'd20);

        // ---- 6: asynchronous reset mid-frame ----
        drive(1'b1, 12'd1500, 16'd3000, 16'd7000, 1'b1, 1'b1, 1'b1);
        wait_pos(4, "wait_slot4");
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_ctl", {28'd0, out_valid, out_sop, out_eop, overrun}, 32'd0);
        check("async_rst_iq", {i_o, q_o}, 32'd0);
        check("async_rst_frames", {16'd0, frames_done}, 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();
        check("post_rst_sop", {30'd0, out_valid, out_sop}, 32'd3);

        // ---- 7: randomized traffic ----
        for (int k = 0; k < 1500; k++) begin
            enable     = ($urandom_range(0, 9) != 0);
            adc_valid  = ($urandom_range(0, 4) != 0);
            nco_valid  = ($urandom_range(0, 9) != 0);
            sink_ready = ($urandom_range(0, 6) != 0);
            ovr_clr    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) begin
                adc_i = 12'h800; nco_sin = 16'h8000; nco_cos = 16'h8000;
            end else begin
                adc_i = DW'($urandom); nco_sin = MPR'($urandom); nco_cos = MPR'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
